// File: rtl/block_scheduler.sv
// block_scheduler: splits a kernel's threads into blocks and hands them round-robin to compute cores.
module block_scheduler #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int BLOCK_ID_BITS     = 8
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic [THREAD_COUNT_BITS-1:0]                            thread_count,
  input  logic [NUM_CORES-1:0]                                    core_done,
  output logic [NUM_CORES-1:0]                                    core_reset,
  output logic [NUM_CORES-1:0]                                    core_start,
  output logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0]                 core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]       core_thread_count,
  output logic                                                    busy,
  output logic                                                    done
);
  localparam int LG   = $clog2(THREADS_PER_BLOCK);
  localparam int CW   = LG + 1;
  localparam int CNTW = BLOCK_ID_BITS + 1;
  localparam int TW   = THREAD_COUNT_BITS + 1;
  localparam int RW   = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
  typedef enum logic [1:0] {S_FREE, S_LOAD, S_RUN} slot_e;
  fsm_e                                fsm_q, fsm_d;
  slot_e                               slot_q [NUM_CORES];
  slot_e                               slot_d [NUM_CORES];
  logic [THREAD_COUNT_BITS-1:0]        t_q, t_d;
  logic [CNTW-1:0]                     total_q, total_d, disp_q, disp_d, ret_q, ret_d;
  logic [RW-1:0]                       rr_q, rr_d, sel, idx;
  logic [NUM_CORES-1:0]                core_reset_q, core_reset_d, core_start_q, core_start_d;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] core_block_id_q, core_block_id_d;
  logic [NUM_CORES-1:0][CW-1:0]        core_thread_count_q, core_thread_count_d;
  logic                                busy_q, busy_d, done_q, done_d;
  logic                                accept, found, dispatch;
  logic [CW-1:0]                       last_cnt;
  assign accept = start && fsm_q != RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q               <= IDLE;
      slot_q              <= '{default: S_FREE};
      t_q                 <= '0;
      total_q             <= '0;
      disp_q              <= '0;
      ret_q               <= '0;
      rr_q                <= '0;
      core_reset_q        <= '1;
      core_start_q        <= '0;
      core_block_id_q     <= '0;
      core_thread_count_q <= '0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      fsm_q               <= fsm_d;
      slot_q              <= slot_d;
      t_q                 <= t_d;
      total_q             <= total_d;
      disp_q              <= disp_d;
      ret_q               <= ret_d;
      rr_q                <= rr_d;
      core_reset_q        <= core_reset_d;
      core_start_q        <= core_start_d;
      core_block_id_q     <= core_block_id_d;
      core_thread_count_q <= core_thread_count_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    if (accept) fsm_d = thread_count == '0 ? DONE : RUN;
    else if (fsm_q == RUN && ret_q == total_q) fsm_d = DONE;
  end
  always_comb begin
    t_d      = accept ? thread_count : t_q;
    total_d  = accept ? CNTW'((TW'(thread_count) + TW'(THREADS_PER_BLOCK - 1)) >> LG) : total_q;
    disp_d   = accept ? '0 : disp_q;
    ret_d    = accept ? '0 : ret_q;
    last_cnt = CW'(int'(t_q) - (int'(total_q) - 1) * THREADS_PER_BLOCK);
    sel      = '0;
    idx      = '0;
    found    = 1'b0;
    // first free slot at or after the round-robin pointer, wrapping
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = RW'((int'(rr_q) + i) % NUM_CORES);
      if (!found && slot_q[idx] == S_FREE) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    dispatch            = fsm_q == RUN && disp_q < total_q && found;
    rr_d                = dispatch ? RW'((int'(sel) + 1) % NUM_CORES) : rr_q;
    disp_d              = dispatch ? disp_q + CNTW'(1) : disp_d;
    slot_d              = slot_q;
    core_reset_d        = '0;
    core_start_d        = core_start_q;
    core_block_id_d     = core_block_id_q;
    core_thread_count_d = core_thread_count_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (dispatch && sel == RW'(k)) begin
        slot_d[k]              = S_LOAD;
        core_reset_d[k]        = 1'b1;
        core_block_id_d[k]     = disp_q[BLOCK_ID_BITS-1:0];
        core_thread_count_d[k] = disp_q == total_q - CNTW'(1) ? last_cnt : CW'(THREADS_PER_BLOCK);
      end else if (slot_q[k] == S_LOAD) begin
        slot_d[k]       = S_RUN;
        core_start_d[k] = 1'b1;
      end else if (slot_q[k] == S_RUN && core_done[k]) begin
        slot_d[k]       = S_FREE;
        core_start_d[k] = 1'b0;
        ret_d           = ret_d + CNTW'(1);
      end
    end
    busy_d = fsm_d == RUN;
    done_d = fsm_d == DONE;
  end
  assign core_reset        = core_reset_q;
  assign core_start        = core_start_q;
  assign core_block_id     = core_block_id_q;
  assign core_thread_count = core_thread_count_q;
  assign busy              = busy_q;
  assign done              = done_q;
endmodule

// File: tb/tb_block_scheduler.sv
// tb_block_scheduler: directed checks of block dispatch, round-robin order, completion and reset.
module tb_block_scheduler;
  logic            clk = 1'b0;
  logic            reset, start;
  logic [7:0]      thread_count;
  logic [1:0]      core_done = '0;
  logic [1:0]      core_reset, core_start;
  logic [1:0][7:0] core_block_id;
  logic [1:0][2:0] core_thread_count;
  logic            busy, done;
  int checks = 0, errors = 0, cyc = 0;
  int lat [2];
  int cnt [2] = '{0, 0};
  int log_q [$];
  int log_cyc [$];
  always #5 clk = ~clk;
  block_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_done(core_done), .core_reset(core_reset), .core_start(core_start),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .busy(busy), .done(done)
  );
  // logs dispatches and models cores that finish lat[k] cycles after core_start rises
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (busy && core_reset[k]) begin
        log_q.push_back(k * 100000 + int'(core_block_id[k]) * 10 + int'(core_thread_count[k]));
        log_cyc.push_back(cyc);
      end
      if (core_start[k]) begin
        cnt[k]++;
        core_done[k] = cnt[k] >= lat[k];
      end else begin
        cnt[k]       = 0;
        core_done[k] = 1'b0;
      end
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_log(input string tag, input int i, input int c, input int id, input int n);
    check(tag, i < log_q.size() ? log_q[i] : -1, c * 100000 + id * 10 + n);
  endtask
  task automatic launch(input int t);
    log_q.delete();
    log_cyc.delete();
    start        = 1'b1;
    thread_count = 8'(t);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    check({tag, " done"}, int'(done), 1);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " start"}, int'(core_start), 0);
  endtask
  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; thread_count = '0; lat = '{3, 3};
    repeat (2) @(negedge clk);
    check("rst done", int'(done), 0);
    check("rst busy", int'(busy), 0);
    check("rst core_start", int'(core_start), 0);
    check("rst core_reset", int'(core_reset), 3);
    check("rst ids", int'(core_block_id), 0);
    check("rst cnts", int'(core_thread_count), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst release core_reset", int'(core_reset), 0);
    check("t0 pre done", int'(done), 0);
    launch(0);
    check("t0 done", int'(done), 1);
    seen = int'(busy);
    repeat (4) begin
      @(negedge clk);
      seen |= int'(core_reset) | int'(core_start) | int'(busy);
    end
    check("t0 quiet", seen, 0);
    launch(8);
    check("t8 busy", int'(busy), 1);
    check("t8 done cleared", int'(done), 0);
    wait_done("t8");
    check("t8 nblk", log_q.size(), 2);
    chk_log("t8 b0", 0, 0, 0, 4);
    chk_log("t8 b1", 1, 1, 1, 4);
    check("t8 gap", log_q.size() == 2 ? log_cyc[1] - log_cyc[0] : -1, 1);
    repeat (3) @(negedge clk);
    check("t8 done sticky", int'(done), 1);
    lat = '{2, 5};
    launch(10);
    wait_done("t10");
    check("t10 nblk", log_q.size(), 3);
    chk_log("t10 b0", 0, 0, 0, 4);
    chk_log("t10 b1", 1, 1, 1, 4);
    chk_log("t10 b2", 2, 0, 2, 2);
    lat = '{3, 3};
    launch(9);
    repeat (3) @(negedge clk);
    start = 1'b1; thread_count = 8'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done("t9");
    check("t9 nblk", log_q.size(), 3);
    chk_log("t9 b0", 0, 1, 0, 4);
    chk_log("t9 b1", 1, 0, 1, 4);
    chk_log("t9 b2", 2, 1, 2, 1);
    launch(4);
    check("t4 done cleared", int'(done), 0);
    check("t4 busy", int'(busy), 1);
    wait_done("t4");
    chk_log("t4 b0", 0, 0, 0, 4);
    lat = '{3, 4};
    launch(16);
    wait_done("t16");
    check("t16 nblk", log_q.size(), 4);
    chk_log("t16 b0", 0, 1, 0, 4);
    chk_log("t16 b1", 1, 0, 1, 4);
    chk_log("t16 b2", 2, 1, 2, 4);
    chk_log("t16 b3", 3, 0, 3, 4);
    check("t16 gap12", log_q.size() == 4 ? log_cyc[2] - log_cyc[1] : -1, 5);
    check("t16 gap23", log_q.size() == 4 ? log_cyc[3] - log_cyc[2] : -1, 1);
    lat = '{1, 1};
    launch(255);
    wait_done("t255");
    check("t255 nblk", log_q.size(), 64);
    check("t255 last", log_q.size() == 64 ? log_q[63] % 100000 : -1, 633);
    lat = '{50, 50};
    launch(16);
    for (int i = 0; i < 20 && core_start != 2'b11; i++) @(negedge clk);
    check("mid start", int'(core_start), 3);
    reset = 1'b1;
    @(negedge clk);
    check("mid rst core_start", int'(core_start), 0);
    check("mid rst core_reset", int'(core_reset), 3);
    check("mid rst done", int'(done), 0);
    check("mid rst busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid release core_reset", int'(core_reset), 0);
    lat = '{3, 3};
    launch(4);
    wait_done("post rst t4");
    check("post rst nblk", log_q.size(), 1);
    chk_log("post rst b0", 0, 0, 0, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
